// File: rtl/regfile_ctrl_pkg.sv
// Shared widths and types for the register-file write-port controller.
// Rev 1.0
`default_nettype none

package regfile_ctrl_pkg;
  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

`default_nettype wire

// File: rtl/regfile_write_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer moves past the winner.
// Rev 1.0
`default_nettype none

module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          any;

  // Scan upward from the pointer with wrap; the first asserted request wins.
  always_comb begin
    int idx;
    grant = '0;
    win   = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (int'(win) + 1 == N) ? '0 : win + PW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_sched.sv
// Arbitrates the single register-file write port and tracks pending writes for hazard stalls.
// Rev 1.0
`default_nettype none

module regfile_write_sched #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = regfile_ctrl_pkg::DATA_W,
  parameter int REG_AW  = regfile_ctrl_pkg::REG_AW
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ*REG_AW-1:0] Req_DR,
  input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
  output logic [NUM_REQ-1:0]        Grant,
  input  logic                      Rsv_En,
  input  logic [REG_AW-1:0]         Rsv_DR,
  output logic                      Rsv_Ready,
  input  logic [REG_AW-1:0]         SR1,
  input  logic [REG_AW-1:0]         SR2,
  output logic                      SR1_Busy,
  output logic                      SR2_Busy,
  output logic                      LD_REG,
  output logic [REG_AW-1:0]         DR_Out,
  output logic [DATA_W-1:0]         Reg_In
);

  import regfile_ctrl_pkg::*;

  localparam int NREG = 2 ** REG_AW;

  logic [REG_AW-1:0] req_dr   [NUM_REQ];
  logic [DATA_W-1:0] req_data [NUM_REQ];
  logic [REG_AW-1:0] sel_dr;
  logic [DATA_W-1:0] sel_data;
  logic              any_grant;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic              rsv_set;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk  (Clk),
    .rst  (Reset),
    .req  (Req),
    .grant(Grant)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_dr[g]   = Req_DR[g*REG_AW +: REG_AW];
    assign req_data[g] = Req_Data[g*DATA_W +: DATA_W];
  end

  // Grant is one-hot, so OR-ing the masked fields selects the winner.
  always_comb begin
    sel_dr   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (Grant[i]) begin
        sel_dr   = sel_dr | req_dr[i];
        sel_data = sel_data | req_data[i];
      end
    end
  end

  assign any_grant = |Grant;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      LD_REG <= 1'b0;
      DR_Out <= '0;
      Reg_In <= '0;
    end else begin
      LD_REG <= any_grant;
      if (any_grant) begin
        DR_Out <= sel_dr;
        Reg_In <= sel_data;
      end
    end
  end

  assign Rsv_Ready = ~pending[Rsv_DR];
  assign SR1_Busy  = pending[SR1];
  assign SR2_Busy  = pending[SR2];
  assign rsv_set   = Rsv_En & Rsv_Ready;

  // Reservation is applied after the commit clear so a same-edge set wins.
  always_comb begin
    pending_nxt = pending;
    if (LD_REG) begin
      pending_nxt[DR_Out] = 1'b0;
    end
    if (rsv_set) begin
      pending_nxt[Rsv_DR] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_sched.sv
// Directed self-checking bench for regfile_write_sched (2 requesters).
// Rev 1.0
`default_nettype none

module tb_regfile_write_sched;
  import regfile_ctrl_pkg::*;

  localparam int NR = 2;

  logic                    Clk = 1'b0;
  logic                    Reset;
  logic [NR-1:0]           Req;
  logic [NR*REG_AW-1:0]    Req_DR;
  logic [NR*DATA_W-1:0]    Req_Data;
  logic [NR-1:0]           Grant;
  logic                    Rsv_En;
  reg_idx_t                Rsv_DR;
  logic                    Rsv_Ready;
  reg_idx_t                SR1;
  reg_idx_t                SR2;
  logic                    SR1_Busy;
  logic                    SR2_Busy;
  logic                    LD_REG;
  reg_idx_t                DR_Out;
  word_t                   Reg_In;

  int checks   = 0;
  int failures = 0;

  regfile_write_sched #(
    .NUM_REQ(NR),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Req      (Req),
    .Req_DR   (Req_DR),
    .Req_Data (Req_Data),
    .Grant    (Grant),
    .Rsv_En   (Rsv_En),
    .Rsv_DR   (Rsv_DR),
    .Rsv_Ready(Rsv_Ready),
    .SR1      (SR1),
    .SR2      (SR2),
    .SR1_Busy (SR1_Busy),
    .SR2_Busy (SR2_Busy),
    .LD_REG   (LD_REG),
    .DR_Out   (DR_Out),
    .Reg_In   (Reg_In)
  );

  always #5 Clk = ~Clk;

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset;
    Reset  = 1'b1;
    Req    = '0;
    Rsv_En = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Req = '0; Req_DR = '0; Req_Data = '0;
    Rsv_En = 1'b0; Rsv_DR = '0; SR1 = '0; SR2 = '0;
    step();
    checks++;
    if (LD_REG !== 1'b0 || DR_Out !== 3'd0 || Reg_In !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: LD_REG=%b DR_Out=%0d Reg_In=%h want 0/0/0000", LD_REG, DR_Out, Reg_In);
    end
    checks++;
    if (SR1_Busy !== 1'b0 || Rsv_Ready !== 1'b1 || Grant !== 2'b00) begin
      failures++;
      $display("FAIL reset_scoreboard: SR1_Busy=%b Rsv_Ready=%b Grant=%b want 0/1/00", SR1_Busy, Rsv_Ready, Grant);
    end
    Reset = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    Req = 2'b01; Req_DR = {3'd0, 3'd4}; Req_Data = {16'h0, 16'h1234};
    Rsv_En = 1'b1; Rsv_DR = 3'd4; SR1 = 3'd4;
    #1;
    checks++;
    if (Grant !== 2'b01) begin
      failures++;
      $display("FAIL midwrite_grant: got %b want 01", Grant);
    end
    step();
    Req = '0; Rsv_En = 1'b0;
    #1;
    checks++;
    if (LD_REG !== 1'b1 || SR1_Busy !== 1'b1) begin
      failures++;
      $display("FAIL midwrite_inflight: LD_REG=%b SR1_Busy=%b want 1/1", LD_REG, SR1_Busy);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (LD_REG !== 1'b0 || DR_Out !== 3'd0 || Reg_In !== 16'h0 || SR1_Busy !== 1'b0) begin
      failures++;
      $display("FAIL midwrite_reset: LD_REG=%b DR_Out=%0d Reg_In=%h SR1_Busy=%b want 0/0/0000/0",
               LD_REG, DR_Out, Reg_In, SR1_Busy);
    end
    step();
    Reset = 1'b0;
    step();
    checks++;
    if (LD_REG !== 1'b0) begin
      failures++;
      $display("FAIL midwrite_no_write: LD_REG=%b want 0", LD_REG);
    end
  endtask

  task automatic test_single;
    Req = 2'b01; Req_DR = {3'd0, 3'd3}; Req_Data = {16'h0, 16'hBEEF};
    #1;
    checks++;
    if (Grant !== 2'b01) begin
      failures++;
      $display("FAIL single_grant: got %b want 01", Grant);
    end
    step();
    Req = '0;
    checks++;
    if (LD_REG !== 1'b1 || DR_Out !== 3'd3 || Reg_In !== 16'hBEEF) begin
      failures++;
      $display("FAIL single_write: LD_REG=%b DR_Out=%0d Reg_In=%h want 1/3/beef", LD_REG, DR_Out, Reg_In);
    end
    step();
    checks++;
    if (LD_REG !== 1'b0 || DR_Out !== 3'd3 || Reg_In !== 16'hBEEF) begin
      failures++;
      $display("FAIL single_idle_hold: LD_REG=%b DR_Out=%0d Reg_In=%h want 0/3/beef", LD_REG, DR_Out, Reg_In);
    end
  endtask

  task automatic test_contention;
    reg_idx_t prev_dr;
    apply_reset();
    Req = 2'b11; Req_DR = {3'd6, 3'd1}; Req_Data = {16'hB1B1, 16'hA0A0};
    prev_dr = '0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (Grant !== exp_g) begin
        failures++;
        $display("FAIL contention_grant%0d: got %b want %b", k, Grant, exp_g);
      end
      if (k > 0) begin
        checks++;
        if (LD_REG !== 1'b1 || DR_Out !== prev_dr) begin
          failures++;
          $display("FAIL contention_write%0d: LD_REG=%b DR_Out=%0d want 1/%0d", k, LD_REG, DR_Out, prev_dr);
        end
      end
      prev_dr = (k % 2 == 0) ? 3'd1 : 3'd6;
      step();
    end
    Req = '0;
    checks++;
    if (LD_REG !== 1'b1 || DR_Out !== 3'd6 || Reg_In !== 16'hB1B1) begin
      failures++;
      $display("FAIL contention_last: LD_REG=%b DR_Out=%0d Reg_In=%h want 1/6/b1b1", LD_REG, DR_Out, Reg_In);
    end
    step();
    checks++;
    if (LD_REG !== 1'b0) begin
      failures++;
      $display("FAIL contention_idle: LD_REG=%b want 0", LD_REG);
    end
  endtask

  task automatic test_scoreboard;
    Rsv_En = 1'b1; Rsv_DR = 3'd5; SR1 = 3'd5; SR2 = 3'd5;
    #1;
    checks++;
    if (Rsv_Ready !== 1'b1 || SR1_Busy !== 1'b0) begin
      failures++;
      $display("FAIL sb_initial: Rsv_Ready=%b SR1_Busy=%b want 1/0", Rsv_Ready, SR1_Busy);
    end
    step();
    checks++;
    if (SR1_Busy !== 1'b1 || SR2_Busy !== 1'b1 || Rsv_Ready !== 1'b0) begin
      failures++;
      $display("FAIL sb_reserved: SR1_Busy=%b SR2_Busy=%b Rsv_Ready=%b want 1/1/0", SR1_Busy, SR2_Busy, Rsv_Ready);
    end
    step();
    Rsv_En = 1'b0;
    Req = 2'b01; Req_DR = {3'd0, 3'd5}; Req_Data = {16'h0, 16'h5555};
    step();
    Req = '0;
    checks++;
    if (LD_REG !== 1'b1 || DR_Out !== 3'd5 || SR1_Busy !== 1'b1) begin
      failures++;
      $display("FAIL sb_commit_cycle: LD_REG=%b DR_Out=%0d SR1_Busy=%b want 1/5/1", LD_REG, DR_Out, SR1_Busy);
    end
    step();
    checks++;
    if (SR1_Busy !== 1'b0 || Rsv_Ready !== 1'b1) begin
      failures++;
      $display("FAIL sb_cleared: SR1_Busy=%b Rsv_Ready=%b want 0/1", SR1_Busy, Rsv_Ready);
    end
  endtask

  task automatic test_same_edge;
    SR1 = 3'd0; SR2 = 3'd2;
    Req = 2'b01; Req_DR = {3'd0, 3'd2}; Req_Data = {16'h0, 16'h2222};
    #1;
    checks++;
    if (SR2_Busy !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_pre: SR2_Busy=%b want 0", SR2_Busy);
    end
    step();
    Req = '0; Rsv_En = 1'b1; Rsv_DR = 3'd2;
    #1;
    checks++;
    if (LD_REG !== 1'b1 || DR_Out !== 3'd2 || Rsv_Ready !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_setup: LD_REG=%b DR_Out=%0d Rsv_Ready=%b want 1/2/1", LD_REG, DR_Out, Rsv_Ready);
    end
    step();
    Rsv_En = 1'b0;
    #1;
    checks++;
    if (SR2_Busy !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_set_wins: SR2_Busy=%b want 1", SR2_Busy);
    end
    Req = 2'b01;
    step();
    Req = '0;
    step();
    checks++;
    if (SR2_Busy !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_cleanup: SR2_Busy=%b want 0", SR2_Busy);
    end
  endtask

  task automatic test_withdraw;
    apply_reset();
    Req = 2'b11; Req_DR = {3'd7, 3'd0}; Req_Data = {16'h7777, 16'h0101};
    #1;
    checks++;
    if (Grant !== 2'b01) begin
      failures++;
      $display("FAIL withdraw_grant: got %b want 01", Grant);
    end
    step();
    Req = '0;
    #1;
    checks++;
    if (Grant !== 2'b00 || LD_REG !== 1'b1 || DR_Out !== 3'd0 || Reg_In !== 16'h0101) begin
      failures++;
      $display("FAIL withdraw_req0_write: Grant=%b LD_REG=%b DR_Out=%0d Reg_In=%h want 00/1/0/0101",
               Grant, LD_REG, DR_Out, Reg_In);
    end
    step();
    checks++;
    if (LD_REG !== 1'b0 || DR_Out !== 3'd0 || Reg_In !== 16'h0101) begin
      failures++;
      $display("FAIL withdraw_no_req1_write: LD_REG=%b DR_Out=%0d Reg_In=%h want 0/0/0101", LD_REG, DR_Out, Reg_In);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_single();
    test_contention();
    test_scoreboard();
    test_same_edge();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
